// File: rtl/fir_sweep_ctrl.sv
// Frequency-sweep controller for a DDS-driven FIR measurement loop.
// Steps the DDS phase increment through num_steps points. Each point waits
// for the FIR to settle, then measures for a dwell window, then advances.
// Optional peak-magnitude tracking during dwell is enabled by FIR_SWEEP_PEAK_EN.
module fir_sweep_ctrl #(
   parameter int unsigned COUNT_WIDTH   = 32,
   parameter int unsigned STEP_WIDTH    = 8,
   parameter int unsigned DWELL_WIDTH   = 16,
   parameter int unsigned OUT_FIR_WIDTH = 44
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            start,
   input  logic                            abort,
   input  logic [COUNT_WIDTH-1:0]          inc_start,
   input  logic [COUNT_WIDTH-1:0]          inc_step,
   input  logic [STEP_WIDTH-1:0]           num_steps,
   input  logic [DWELL_WIDTH-1:0]          settle_len,
   input  logic [DWELL_WIDTH-1:0]          dwell_len,
   input  logic signed [OUT_FIR_WIDTH-1:0] fir_out,
   output logic [COUNT_WIDTH-1:0]          phase_inc,
   output logic [STEP_WIDTH-1:0]           step_idx,
   output logic                            meas_en,
   output logic                            busy,
   output logic                            done,
   output logic [OUT_FIR_WIDTH-1:0]        peak,
   output logic                            peak_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_DWELL,
      S_STEP,
      S_DONE
   } state_e;

   state_e                  state_q;
   logic [COUNT_WIDTH-1:0]  inc_step_q;
   logic [STEP_WIDTH-1:0]   num_steps_q;
   logic [DWELL_WIDTH-1:0]  settle_len_q;
   logic [DWELL_WIDTH-1:0]  dwell_len_q;
   logic [DWELL_WIDTH-1:0]  timer_q;
   logic [COUNT_WIDTH-1:0]  phase_inc_q;
   logic [STEP_WIDTH-1:0]   step_idx_q;
   logic                    meas_en_q;
   logic                    busy_q;
   logic                    done_q;

   logic settle_last;
   logic dwell_last;
   logic last_point;

   // End-of-phase decodes; a zero length behaves as a one-cycle phase
   always_comb begin
      settle_last = (settle_len_q == '0) || (timer_q == settle_len_q - DWELL_WIDTH'(1));
      dwell_last  = (dwell_len_q == '0)  || (timer_q == dwell_len_q - DWELL_WIDTH'(1));
      last_point  = (step_idx_q == num_steps_q - STEP_WIDTH'(1));
   end

   // Sweep sequencer; abort outranks every other transition outside IDLE
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         inc_step_q   <= '0;
         num_steps_q  <= '0;
         settle_len_q <= '0;
         dwell_len_q  <= '0;
         timer_q      <= '0;
         phase_inc_q  <= '0;
         step_idx_q   <= '0;
         meas_en_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q != S_IDLE && abort) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            meas_en_q <= 1'b0;
            timer_q   <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     inc_step_q   <= inc_step;
                     num_steps_q  <= num_steps;
                     settle_len_q <= settle_len;
                     dwell_len_q  <= dwell_len;
                     timer_q      <= '0;
                     busy_q       <= 1'b1;
                     if (num_steps != '0) begin
                        phase_inc_q <= inc_start;
                        step_idx_q  <= '0;
                        state_q     <= S_SETTLE;
                     end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end
                  end
               end
               S_SETTLE: begin
                  if (settle_last) begin
                     timer_q   <= '0;
                     meas_en_q <= 1'b1;
                     state_q   <= S_DWELL;
                  end else begin
                     timer_q <= timer_q + DWELL_WIDTH'(1);
                  end
               end
               S_DWELL: begin
                  if (dwell_last) begin
                     timer_q   <= '0;
                     meas_en_q <= 1'b0;
                     state_q   <= S_STEP;
                  end else begin
                     timer_q <= timer_q + DWELL_WIDTH'(1);
                  end
               end
               S_STEP: begin
                  if (last_point) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     step_idx_q  <= step_idx_q + STEP_WIDTH'(1);
                     phase_inc_q <= phase_inc_q + inc_step_q;
                     state_q     <= S_SETTLE;
                  end
               end
               S_DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  busy_q    <= 1'b0;
                  meas_en_q <= 1'b0;
                  state_q   <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign phase_inc = phase_inc_q;
   assign step_idx  = step_idx_q;
   assign meas_en   = meas_en_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef FIR_SWEEP_PEAK_EN
   localparam logic [OUT_FIR_WIDTH-1:0] MOST_NEG = {1'b1, {(OUT_FIR_WIDTH-1){1'b0}}};
   localparam logic [OUT_FIR_WIDTH-1:0] MAX_POS  = {1'b0, {(OUT_FIR_WIDTH-1){1'b1}}};

   logic [OUT_FIR_WIDTH-1:0] fir_abs;
   logic [OUT_FIR_WIDTH-1:0] peak_q;
   logic                     peak_valid_q;

   // Magnitude of the FIR word; the most-negative code saturates
   always_comb begin
      fir_abs = $unsigned(fir_out);
      if (fir_out[OUT_FIR_WIDTH-1]) begin
         if ($unsigned(fir_out) == MOST_NEG) begin
            fir_abs = MAX_POS;
         end else begin
            fir_abs = OUT_FIR_WIDTH'($unsigned(-fir_out));
         end
      end
   end

   // Peak tracker: restart on the first dwell cycle, hold outside dwell
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         peak_q       <= '0;
         peak_valid_q <= 1'b0;
      end else begin
         peak_valid_q <= 1'b0;
         if (state_q == S_DWELL && !abort) begin
            if (timer_q == '0 || fir_abs > peak_q) begin
               peak_q <= fir_abs;
            end
            peak_valid_q <= dwell_last;
         end
      end
   end

   assign peak       = peak_q;
   assign peak_valid = peak_valid_q;
`else
   logic unused_fir_out;

   assign unused_fir_out = ^fir_out;
   assign peak           = '0;
   assign peak_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sweep_ctrl.sv
// Directed bench for fir_sweep_ctrl: sweep timing, wrap-around, empty sweep,
// abort, zero-length phases, start/config changes mid-sweep, peak tracking
// and asynchronous reset.
module tb_fir_sweep_ctrl;

   localparam int unsigned CW = 32;
   localparam int unsigned SW = 8;
   localparam int unsigned DW = 16;
   localparam int unsigned FW = 44;

`ifdef FIR_SWEEP_PEAK_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   localparam logic [FW-1:0] MOST_NEG = {1'b1, {(FW-1){1'b0}}};
   localparam logic [FW-1:0] MAX_POS  = {1'b0, {(FW-1){1'b1}}};

   logic                 i_clk;
   logic                 i_rst_n;
   logic                 start;
   logic                 abort;
   logic [CW-1:0]        inc_start;
   logic [CW-1:0]        inc_step;
   logic [SW-1:0]        num_steps;
   logic [DW-1:0]        settle_len;
   logic [DW-1:0]        dwell_len;
   logic signed [FW-1:0] fir_out;
   logic [CW-1:0]        phase_inc;
   logic [SW-1:0]        step_idx;
   logic                 meas_en;
   logic                 busy;
   logic                 done;
   logic [FW-1:0]        peak;
   logic                 peak_valid;

   int checks = 0;
   int errors = 0;

   fir_sweep_ctrl #(
      .COUNT_WIDTH   (CW),
      .STEP_WIDTH    (SW),
      .DWELL_WIDTH   (DW),
      .OUT_FIR_WIDTH (FW)
   ) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .start      (start),
      .abort      (abort),
      .inc_start  (inc_start),
      .inc_step   (inc_step),
      .num_steps  (num_steps),
      .settle_len (settle_len),
      .dwell_len  (dwell_len),
      .fir_out    (fir_out),
      .phase_inc  (phase_inc),
      .step_idx   (step_idx),
      .meas_en    (meas_en),
      .busy       (busy),
      .done       (done),
      .peak       (peak),
      .peak_valid (peak_valid)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled at the falling edge
   task automatic tick();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   // Walk one sweep point starting in its first settle cycle
   task automatic run_point(input logic [CW-1:0] inc, input logic [SW-1:0] idx,
                            input int s, input int d);
      for (int c = 0; c <= s + d; c++) begin
         chk("pt_phase", 64'(phase_inc), 64'(inc));
         chk("pt_idx", 64'(step_idx), 64'(idx));
         chk("pt_meas", 64'(meas_en), 64'((c >= s) && (c < s + d)));
         chk("pt_busy", 64'(busy), 64'd1);
         chk("pt_done", 64'(done), 64'd0);
         chk("pt_pvalid", 64'(peak_valid), 64'((c == s + d) ? PEAK_EN : 1'b0));
         tick();
      end
   endtask

   initial begin
      i_rst_n    = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      inc_start  = '0;
      inc_step   = '0;
      num_steps  = '0;
      settle_len = '0;
      dwell_len  = '0;
      fir_out    = '0;

      // Reset state
      #1 i_rst_n = 1'b0;
      #2;
      chk("rst_phase", 64'(phase_inc), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_meas", 64'(meas_en), 64'd0);
      chk("rst_peak", 64'(peak), 64'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick();
      chk("idle_busy", 64'(busy), 64'd0);

      // Three-point sweep, 4 settle + 8 dwell + 1 step per point
      inc_start  = 32'h0200_0000;
      inc_step   = 32'h0200_0000;
      num_steps  = 8'd3;
      settle_len = 16'd4;
      dwell_len  = 16'd8;
      start      = 1'b1;
      tick();
      start = 1'b0;
      run_point(32'h0200_0000, 8'd0, 4, 8);
      run_point(32'h0400_0000, 8'd1, 4, 8);
      run_point(32'h0600_0000, 8'd2, 4, 8);
      chk("s1_done", 64'(done), 64'd1);
      chk("s1_done_busy", 64'(busy), 64'd1);
      tick();
      chk("s1_done_pulse", 64'(done), 64'd0);
      chk("s1_idle_busy", 64'(busy), 64'd0);
      chk("s1_idx_hold", 64'(step_idx), 64'd2);
      chk("s1_phase_hold", 64'(phase_inc), 64'h0600_0000);

      // Phase increment wrap-around
      inc_start  = 32'hFFFF_FFF0;
      inc_step   = 32'h0000_0020;
      num_steps  = 8'd2;
      settle_len = 16'd1;
      dwell_len  = 16'd1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      run_point(32'hFFFF_FFF0, 8'd0, 1, 1);
      run_point(32'h0000_0010, 8'd1, 1, 1);
      chk("s2_done", 64'(done), 64'd1);
      tick();
      chk("s2_idle_busy", 64'(busy), 64'd0);

      // Empty sweep: done right away, busy for one cycle, phase untouched
      inc_start = 32'hDEAD_BEEF;
      num_steps = 8'd0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk("s3_done", 64'(done), 64'd1);
      chk("s3_busy", 64'(busy), 64'd1);
      chk("s3_phase", 64'(phase_inc), 64'h0000_0010);
      tick();
      chk("s3_done_pulse", 64'(done), 64'd0);
      chk("s3_busy_off", 64'(busy), 64'd0);
      chk("s3_phase_hold", 64'(phase_inc), 64'h0000_0010);

      // Abort on the third dwell cycle of the first point
      inc_start  = 32'h0000_0100;
      inc_step   = 32'h0000_0100;
      num_steps  = 8'd3;
      settle_len = 16'd2;
      dwell_len  = 16'd5;
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("s4_dwell1", 64'(meas_en), 64'd1);
      tick();
      tick();
      chk("s4_dwell3", 64'(meas_en), 64'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("s4_abort_busy", 64'(busy), 64'd0);
      chk("s4_abort_meas", 64'(meas_en), 64'd0);
      chk("s4_abort_done", 64'(done), 64'd0);
      chk("s4_abort_phase", 64'(phase_inc), 64'h0000_0100);
      tick();
      chk("s4_no_done", 64'(done), 64'd0);
      chk("s4_still_idle", 64'(busy), 64'd0);
      inc_start  = 32'h0000_0300;
      num_steps  = 8'd1;
      settle_len = 16'd0;
      dwell_len  = 16'd0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      run_point(32'h0000_0300, 8'd0, 1, 1);
      chk("s4_restart_done", 64'(done), 64'd1);
      tick();

      // Zero-length phases, start held high, config changed mid-sweep
      inc_start  = 32'h0000_1000;
      inc_step   = 32'h0000_0010;
      num_steps  = 8'd3;
      settle_len = 16'd0;
      dwell_len  = 16'd0;
      start      = 1'b1;
      tick();
      inc_step   = 32'h0000_FFFF;
      num_steps  = 8'd1;
      settle_len = 16'd7;
      run_point(32'h0000_1000, 8'd0, 1, 1);
      run_point(32'h0000_1010, 8'd1, 1, 1);
      run_point(32'h0000_1020, 8'd2, 1, 1);
      chk("s5_done", 64'(done), 64'd1);
      tick();
      chk("s5_idle", 64'(busy), 64'd0);
      tick();
      chk("s5_restart_busy", 64'(busy), 64'd1);
      chk("s5_restart_phase", 64'(phase_inc), 64'h0000_1000);
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("s5_abort_busy", 64'(busy), 64'd0);

      // Peak tracking over dwell: +100, -300, most-negative
      inc_start  = 32'h0000_0040;
      num_steps  = 8'd1;
      settle_len = 16'd1;
      dwell_len  = 16'd3;
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      fir_out = 44'sd100;
      tick();
      chk("pk_after_pos", 64'(peak), PEAK_EN ? 64'd100 : 64'd0);
      fir_out = -44'sd300;
      tick();
      chk("pk_after_neg", 64'(peak), PEAK_EN ? 64'd300 : 64'd0);
      fir_out = $signed(MOST_NEG);
      tick();
      fir_out = '0;
      chk("pk_sat", 64'(peak), PEAK_EN ? 64'(MAX_POS) : 64'd0);
      chk("pk_valid_step", 64'(peak_valid), 64'(PEAK_EN));
      tick();
      chk("pk_valid_pulse", 64'(peak_valid), 64'd0);
      chk("pk_hold", 64'(peak), PEAK_EN ? 64'(MAX_POS) : 64'd0);
      chk("pk_done", 64'(done), 64'd1);
      tick();

      // Asynchronous reset in the middle of dwell
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      fir_out = 44'sd50;
      tick();
      chk("rr_meas_pre", 64'(meas_en), 64'd1);
      #1 i_rst_n = 1'b0;
      #1;
      chk("rr_phase", 64'(phase_inc), 64'd0);
      chk("rr_idx", 64'(step_idx), 64'd0);
      chk("rr_meas", 64'(meas_en), 64'd0);
      chk("rr_busy", 64'(busy), 64'd0);
      chk("rr_done", 64'(done), 64'd0);
      chk("rr_peak", 64'(peak), 64'd0);
      chk("rr_pvalid", 64'(peak_valid), 64'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      fir_out = '0;
      tick();
      tick();
      chk("rr_wait_idle", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
